// File: rtl/oc_collector_array_if.sv
// Signal bundle between the RAU, register-file banks, execute scheduler and the operand-collector array.
// master drives allocation, bank returns and grants; slave is the collector array itself.
interface oc_collector_array_if #(
  parameter int NUM_OC    = 4,
  parameter int NUM_BANKS = 4,
  parameter int NUM_SRC   = 2,
  parameter int DATA_W    = 256,
  parameter int META_W    = 72
);
  localparam int OCID_W = (NUM_OC > 1) ? $clog2(NUM_OC) : 1;
  localparam int SLOT_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic                        alloc_valid;
  logic                        alloc_ready;
  logic [OCID_W-1:0]           alloc_ocid;
  logic [META_W-1:0]           alloc_meta;
  logic [NUM_SRC-1:0]          alloc_src_need;
  logic [NUM_SRC-1:0]          alloc_byp_valid;
  logic [NUM_SRC*DATA_W-1:0]   alloc_byp_data;

  logic [NUM_BANKS-1:0]        bk_rd_valid;
  logic [NUM_BANKS*OCID_W-1:0] bk_rd_ocid;
  logic [NUM_BANKS*SLOT_W-1:0] bk_rd_slot;
  logic [NUM_BANKS*DATA_W-1:0] bk_rd_data;

  logic [NUM_OC-1:0]           oc_rdy;
  logic [NUM_OC-1:0]           grant;

  logic                        disp_valid;
  logic [OCID_W-1:0]           disp_ocid;
  logic [META_W-1:0]           disp_meta;
  logic [NUM_SRC*DATA_W-1:0]   disp_data;

  logic [OCID_W:0]             occupancy;
  logic                        err;

  modport master (
    output alloc_valid, alloc_meta, alloc_src_need, alloc_byp_valid, alloc_byp_data,
    output bk_rd_valid, bk_rd_ocid, bk_rd_slot, bk_rd_data,
    output grant,
    input  alloc_ready, alloc_ocid, oc_rdy,
    input  disp_valid, disp_ocid, disp_meta, disp_data,
    input  occupancy, err
  );

  modport slave (
    input  alloc_valid, alloc_meta, alloc_src_need, alloc_byp_valid, alloc_byp_data,
    input  bk_rd_valid, bk_rd_ocid, bk_rd_slot, bk_rd_data,
    input  grant,
    output alloc_ready, alloc_ocid, oc_rdy,
    output disp_valid, disp_ocid, disp_meta, disp_data,
    output occupancy, err
  );
endinterface

// File: rtl/oc_collector_array.sv
// Operand-collector array: per-entry IDLE/COLLECT/READY tracking, operand gathering from
// bank returns or RAU bypass, and registered dispatch of granted entries.
module oc_collector_array #(
  parameter int NUM_OC    = 4,
  parameter int NUM_BANKS = 4,
  parameter int NUM_SRC   = 2,
  parameter int DATA_W    = 256,
  parameter int META_W    = 72
) (
  input logic                 clk,
  input logic                 rst,
  oc_collector_array_if.slave oc_bus
);
  localparam int OCID_W = (NUM_OC > 1) ? $clog2(NUM_OC) : 1;
  localparam int SLOT_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int OCC_W  = OCID_W + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    READY   = 2'd2
  } oc_state_t;

  oc_state_t                 state_q   [NUM_OC];
  oc_state_t                 state_nxt [NUM_OC];
  logic [NUM_SRC-1:0]        pend_q    [NUM_OC];
  logic [NUM_SRC-1:0]        pend_nxt  [NUM_OC];
  logic [META_W-1:0]         meta_q    [NUM_OC];
  logic [DATA_W-1:0]         data_q    [NUM_OC][NUM_SRC];
  logic [DATA_W-1:0]         wr_val    [NUM_OC][NUM_SRC];
  logic [NUM_SRC-1:0]        wr_en     [NUM_OC];

  logic [OCC_W-1:0]          occ_q;
  logic [OCC_W-1:0]          occ_nxt;
  logic                      err_q;
  logic                      err_nxt;

  logic                      any_free;
  logic [OCID_W-1:0]         free_id;
  logic                      alloc_fire;
  logic [NUM_SRC-1:0]        alloc_pend;
  logic                      disp_fire;
  logic [OCID_W-1:0]         grant_id;
  logic [OCID_W-1:0]         b_oc;
  logic [SLOT_W-1:0]         b_sl;
  logic [NUM_OC-1:0]         rdy_vec;

  logic                      disp_valid_q;
  logic [OCID_W-1:0]         disp_ocid_q;
  logic [META_W-1:0]         disp_meta_q;
  logic [NUM_SRC*DATA_W-1:0] disp_data_q;

  // Lowest-index IDLE entry; an entry freed by this cycle's grant is not yet visible here.
  always_comb begin
    any_free = 1'b0;
    free_id  = '0;
    for (int i = NUM_OC - 1; i >= 0; i--) begin
      if (state_q[i] == IDLE) begin
        any_free = 1'b1;
        free_id  = OCID_W'(i);
      end
    end
  end

  assign alloc_fire = oc_bus.alloc_valid & any_free;
  assign alloc_pend = oc_bus.alloc_src_need & ~oc_bus.alloc_byp_valid;

  always_comb begin
    for (int i = 0; i < NUM_OC; i++) begin
      rdy_vec[i] = (state_q[i] == READY);
    end
  end

  always_comb begin
    state_nxt = state_q;
    pend_nxt  = pend_q;
    err_nxt   = err_q;
    disp_fire = 1'b0;
    grant_id  = '0;
    b_oc      = '0;
    b_sl      = '0;
    for (int e = 0; e < NUM_OC; e++) begin
      wr_en[e] = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
        wr_val[e][s] = '0;
      end
    end

    // Grant is judged on the pre-edge state so a same-edge READY transition cannot be dispatched.
    for (int i = 0; i < NUM_OC; i++) begin
      if (oc_bus.grant[i]) begin
        grant_id = OCID_W'(i);
      end
    end
    if (oc_bus.grant != '0) begin
      if (((oc_bus.grant & (oc_bus.grant - NUM_OC'(1))) == '0) && (state_q[grant_id] == READY)) begin
        disp_fire           = 1'b1;
        state_nxt[grant_id] = IDLE;
      end else begin
        err_nxt = 1'b1;
      end
    end

    // Clearing the pending bit on the first hit makes lower-index banks win duplicate targets.
    for (int b = 0; b < NUM_BANKS; b++) begin
      b_oc = oc_bus.bk_rd_ocid[b*OCID_W +: OCID_W];
      b_sl = oc_bus.bk_rd_slot[b*SLOT_W +: SLOT_W];
      if (oc_bus.bk_rd_valid[b]) begin
        if ((int'(b_oc) < NUM_OC) && (int'(b_sl) < NUM_SRC) &&
            (state_q[b_oc] == COLLECT) && pend_nxt[b_oc][b_sl]) begin
          pend_nxt[b_oc][b_sl] = 1'b0;
          wr_en[b_oc][b_sl]    = 1'b1;
          wr_val[b_oc][b_sl]   = oc_bus.bk_rd_data[b*DATA_W +: DATA_W];
        end else begin
          err_nxt = 1'b1;
        end
      end
    end

    for (int e = 0; e < NUM_OC; e++) begin
      if ((state_q[e] == COLLECT) && (pend_nxt[e] == '0)) begin
        state_nxt[e] = READY;
      end
    end

    if (alloc_fire) begin
      state_nxt[free_id] = (alloc_pend == '0) ? READY : COLLECT;
      pend_nxt[free_id]  = alloc_pend;
      for (int s = 0; s < NUM_SRC; s++) begin
        wr_en[free_id][s]  = 1'b1;
        wr_val[free_id][s] = oc_bus.alloc_byp_valid[s] ? oc_bus.alloc_byp_data[s*DATA_W +: DATA_W] : '0;
      end
    end

    case ({alloc_fire, disp_fire})
      2'b10:   occ_nxt = occ_q + OCC_W'(1);
      2'b01:   occ_nxt = occ_q - OCC_W'(1);
      default: occ_nxt = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < NUM_OC; e++) begin
        state_q[e] <= IDLE;
        pend_q[e]  <= '0;
      end
      occ_q        <= '0;
      err_q        <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_ocid_q  <= '0;
      disp_meta_q  <= '0;
      disp_data_q  <= '0;
    end else begin
      for (int e = 0; e < NUM_OC; e++) begin
        state_q[e] <= state_nxt[e];
        pend_q[e]  <= pend_nxt[e];
      end
      occ_q        <= occ_nxt;
      err_q        <= err_nxt;
      disp_valid_q <= disp_fire;
      if (disp_fire) begin
        disp_ocid_q <= grant_id;
        disp_meta_q <= meta_q[grant_id];
        for (int s = 0; s < NUM_SRC; s++) begin
          disp_data_q[s*DATA_W +: DATA_W] <= data_q[grant_id][s];
        end
      end
    end
  end

  // Operand and metadata payload needs no reset; state bits gate every use of it.
  always_ff @(posedge clk) begin
    for (int e = 0; e < NUM_OC; e++) begin
      if (alloc_fire && (free_id == OCID_W'(e))) begin
        meta_q[e] <= oc_bus.alloc_meta;
      end
      for (int s = 0; s < NUM_SRC; s++) begin
        if (wr_en[e][s]) begin
          data_q[e][s] <= wr_val[e][s];
        end
      end
    end
  end

  assign oc_bus.alloc_ready = any_free;
  assign oc_bus.alloc_ocid  = free_id;
  assign oc_bus.oc_rdy      = rdy_vec;
  assign oc_bus.disp_valid  = disp_valid_q;
  assign oc_bus.disp_ocid   = disp_ocid_q;
  assign oc_bus.disp_meta   = disp_meta_q;
  assign oc_bus.disp_data   = disp_data_q;
  assign oc_bus.occupancy   = occ_q;
  assign oc_bus.err         = err_q;

endmodule

// File: tb/tb_oc_collector_array.sv
// Bench for oc_collector_array: directed scenarios plus random traffic, all checked against
// an entry-level reference model (busy flag, pending-slot mask, stored operands).
module tb_oc_collector_array;
  localparam int NOC = 4;
  localparam int NB  = 4;
  localparam int NS  = 2;
  localparam int DW  = 256;
  localparam int MW  = 72;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  oc_collector_array_if #(.NUM_OC(NOC), .NUM_BANKS(NB), .NUM_SRC(NS), .DATA_W(DW), .META_W(MW)) bus ();

  oc_collector_array #(.NUM_OC(NOC), .NUM_BANKS(NB), .NUM_SRC(NS), .DATA_W(DW), .META_W(MW)) dut (
    .clk    (clk),
    .rst    (rst),
    .oc_bus (bus)
  );

  int total = 0;
  int bad   = 0;

  bit              m_busy [NOC];
  logic [NS-1:0]   m_pend [NOC];
  logic [NS-1:0]   m_mask [NOC];
  logic [DW-1:0]   m_data [NOC][NS];
  logic [MW-1:0]   m_meta [NOC];
  bit              m_err;
  bit              e_dv;
  int              e_docid;
  logic [MW-1:0]   e_dmeta;
  logic [NS*DW-1:0] e_ddata;
  logic [NS-1:0]   e_dmask;

  task automatic checkOutput(input string tag, input logic [NS*DW-1:0] got, input logic [NS*DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand256();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [MW-1:0] rand72();
    return {$urandom, $urandom, 8'($urandom)};
  endfunction

  function automatic logic [NS*DW-1:0] expand(input logic [NS-1:0] m);
    logic [NS*DW-1:0] r;
    for (int s = 0; s < NS; s++) r[s*DW +: DW] = {DW{m[s]}};
    return r;
  endfunction

  function automatic int model_free_id();
    for (int i = 0; i < NOC; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic bit model_ready(input int i);
    return m_busy[i] && (m_pend[i] == '0);
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < NOC; i++) if (m_busy[i]) n++;
    return n;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NOC; i++) begin
      m_busy[i] = 1'b0;
      m_pend[i] = '0;
      m_mask[i] = '0;
    end
    m_err   = 1'b0;
    e_dv    = 1'b0;
    e_docid = 0;
    e_dmeta = '0;
    e_ddata = '0;
    e_dmask = '1;
  endfunction

  // Applies one clock edge of the rules to the model, using the inputs currently driven.
  function automatic void model_edge();
    int fid;
    int g;
    int oc;
    int sl;
    if (rst) begin
      model_reset();
      return;
    end
    fid  = model_free_id();
    g    = -1;
    e_dv = 1'b0;
    if (bus.grant != '0) begin
      if ($countones(bus.grant) == 1)
        for (int i = 0; i < NOC; i++) if (bus.grant[i]) g = i;
      if (g >= 0 && model_ready(g)) begin
        e_dv    = 1'b1;
        e_docid = g;
        e_dmeta = m_meta[g];
        e_ddata = {m_data[g][1], m_data[g][0]};
        e_dmask = m_mask[g];
      end else begin
        m_err = 1'b1;
      end
    end
    for (int b = 0; b < NB; b++) begin
      if (bus.bk_rd_valid[b]) begin
        oc = int'(bus.bk_rd_ocid[b*2 +: 2]);
        sl = int'(bus.bk_rd_slot[b]);
        if (m_busy[oc] && m_pend[oc][sl]) begin
          m_pend[oc][sl] = 1'b0;
          m_data[oc][sl] = bus.bk_rd_data[b*DW +: DW];
        end else begin
          m_err = 1'b1;
        end
      end
    end
    if (e_dv) m_busy[g] = 1'b0;
    if (bus.alloc_valid && fid >= 0) begin
      m_busy[fid] = 1'b1;
      m_pend[fid] = bus.alloc_src_need & ~bus.alloc_byp_valid;
      m_mask[fid] = bus.alloc_src_need | bus.alloc_byp_valid;
      m_meta[fid] = bus.alloc_meta;
      for (int s = 0; s < NS; s++)
        if (bus.alloc_byp_valid[s]) m_data[fid][s] = bus.alloc_byp_data[s*DW +: DW];
    end
  endfunction

  task automatic clear_inputs();
    bus.alloc_valid     = 1'b0;
    bus.alloc_meta      = '0;
    bus.alloc_src_need  = '0;
    bus.alloc_byp_valid = '0;
    bus.alloc_byp_data  = '0;
    bus.bk_rd_valid     = '0;
    bus.bk_rd_ocid      = '0;
    bus.bk_rd_slot      = '0;
    bus.bk_rd_data      = '0;
    bus.grant           = '0;
  endtask

  task automatic set_alloc(input logic [NS-1:0] need, input logic [NS-1:0] byp,
                           input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [MW-1:0] meta);
    bus.alloc_valid     = 1'b1;
    bus.alloc_src_need  = need;
    bus.alloc_byp_valid = byp;
    bus.alloc_byp_data  = {d1, d0};
    bus.alloc_meta      = meta;
  endtask

  task automatic set_bank(input int b, input int oc, input int sl, input logic [DW-1:0] d);
    bus.bk_rd_valid[b]           = 1'b1;
    bus.bk_rd_ocid[b*2 +: 2]     = 2'(oc);
    bus.bk_rd_slot[b]            = 1'(sl);
    bus.bk_rd_data[b*DW +: DW]   = d;
  endtask

  // One clock: check combinational outputs, advance model, clock, check registered outputs.
  task automatic applyStimulus();
    logic [NOC-1:0] exp_rdy;
    int fid;
    fid = model_free_id();
    checkOutput("alloc_ready", bus.alloc_ready, fid >= 0);
    if (fid >= 0) checkOutput("alloc_ocid", bus.alloc_ocid, fid);
    model_edge();
    @(posedge clk);
    #1;
    clear_inputs();
    checkOutput("disp_valid", bus.disp_valid, e_dv);
    checkOutput("disp_ocid", bus.disp_ocid, e_docid);
    checkOutput("disp_meta", bus.disp_meta, e_dmeta);
    checkOutput("disp_data", bus.disp_data & expand(e_dmask), e_ddata & expand(e_dmask));
    for (int i = 0; i < NOC; i++) exp_rdy[i] = model_ready(i);
    checkOutput("oc_rdy", bus.oc_rdy, exp_rdy);
    checkOutput("occupancy", bus.occupancy, model_count());
    checkOutput("err", bus.err, m_err);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
  endtask

  logic [DW-1:0] va, vb;
  int cand[$];
  int rdy_list[$];
  int pick;

  initial begin
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    do_reset();
    checkOutput("reset_occ", bus.occupancy, 0);
    checkOutput("reset_rdy", bus.oc_rdy, 0);

    // Two bank returns complete entry 0, then dispatch.
    va = rand256();
    vb = rand256();
    set_alloc(2'b11, 2'b00, '0, '0, 72'h123);
    applyStimulus();
    set_bank(0, 0, 0, va);
    applyStimulus();
    checkOutput("t1_not_rdy", bus.oc_rdy[0], 1'b0);
    set_bank(2, 0, 1, vb);
    applyStimulus();
    checkOutput("t1_rdy", bus.oc_rdy[0], 1'b1);
    bus.grant = 4'b0001;
    applyStimulus();
    checkOutput("t1_dv", bus.disp_valid, 1'b1);
    checkOutput("t1_data", bus.disp_data, {vb, va});
    applyStimulus();
    checkOutput("t1_dv_low", bus.disp_valid, 1'b0);
    checkOutput("t1_err", bus.err, 1'b0);

    // Full bypass goes straight to READY.
    set_alloc(2'b00, 2'b11, 256'hA, 256'hB, 72'h55);
    applyStimulus();
    checkOutput("t2_rdy", bus.oc_rdy[0], 1'b1);
    bus.grant = 4'b0001;
    applyStimulus();
    checkOutput("t2_data", bus.disp_data, {256'hB, 256'hA});

    // Fill all entries; freed entry 2 reappears only after the grant edge.
    do_reset();
    for (int i = 0; i < NOC; i++) begin
      set_alloc(2'b00, 2'b11, rand256(), rand256(), rand72());
      applyStimulus();
    end
    checkOutput("t3_occ", bus.occupancy, 4);
    checkOutput("t3_full", bus.alloc_ready, 1'b0);
    bus.grant = 4'b0100;
    set_alloc(2'b00, 2'b11, rand256(), rand256(), rand72());
    applyStimulus();
    checkOutput("t3_ready", bus.alloc_ready, 1'b1);
    checkOutput("t3_ocid", bus.alloc_ocid, 2);

    // Duplicate target from banks 1 and 3: bank 1 wins.
    do_reset();
    set_alloc(2'b11, 2'b00, '0, '0, rand72());
    applyStimulus();
    set_alloc(2'b11, 2'b00, '0, '0, rand72());
    applyStimulus();
    va = rand256();
    vb = rand256();
    set_bank(1, 1, 0, va);
    set_bank(3, 1, 0, vb);
    applyStimulus();
    checkOutput("t4_err", bus.err, 1'b1);
    set_bank(0, 1, 1, rand256());
    applyStimulus();
    bus.grant = 4'b0010;
    applyStimulus();
    checkOutput("t4_slot0", bus.disp_data[DW-1:0], va);

    // Simultaneous alloc and dispatch at occupancy 3, then grant to a collecting entry.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_alloc(2'b00, 2'b01, rand256(), '0, rand72());
      applyStimulus();
    end
    set_alloc(2'b00, 2'b01, rand256(), '0, rand72());
    bus.grant = 4'b0001;
    applyStimulus();
    checkOutput("t5_occ", bus.occupancy, 3);
    set_alloc(2'b01, 2'b00, '0, '0, rand72());
    applyStimulus();
    bus.grant = 4'b0001;
    applyStimulus();
    checkOutput("t5_nodisp", bus.disp_valid, 1'b0);
    checkOutput("t5_err", bus.err, 1'b1);

    // Reset mid-collection discards everything; late returns are errors.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_alloc(2'b11, 2'b00, '0, '0, rand72());
      applyStimulus();
    end
    do_reset();
    checkOutput("t6_occ", bus.occupancy, 0);
    checkOutput("t6_rdy", bus.oc_rdy, 0);
    set_bank(0, 0, 0, rand256());
    set_bank(1, 1, 1, rand256());
    applyStimulus();
    checkOutput("t6_err", bus.err, 1'b1);

    // Random traffic.
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      if ($urandom_range(0, 1) == 1)
        set_alloc(2'($urandom), 2'($urandom), rand256(), rand256(), rand72());
      cand.delete();
      for (int i = 0; i < NOC; i++)
        for (int s = 0; s < NS; s++)
          if (m_busy[i] && m_pend[i][s]) cand.push_back(i * 2 + s);
      for (int b = 0; b < NB; b++) begin
        if ($urandom_range(0, 9) < 4) begin
          if (cand.size() > 0 && $urandom_range(0, 19) != 0) begin
            pick = cand[$urandom_range(0, cand.size() - 1)];
            set_bank(b, pick / 2, pick % 2, rand256());
          end else begin
            set_bank(b, $urandom_range(0, NOC - 1), $urandom_range(0, NS - 1), rand256());
          end
        end
      end
      rdy_list.delete();
      for (int i = 0; i < NOC; i++) if (model_ready(i)) rdy_list.push_back(i);
      pick = $urandom_range(0, 99);
      if (pick < 60 && rdy_list.size() > 0)
        bus.grant = 4'(1 << rdy_list[$urandom_range(0, rdy_list.size() - 1)]);
      else if (pick < 62)
        bus.grant = 4'($urandom);
      applyStimulus();
      rst = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
